counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Command-driven controller for an 8-bit up-counter datapath.
//  - Accepts CLEAR / LOAD / RUN-N / RUN-TO commands over a valid/ready handshake.
//  - Sequences the counter's load and enable controls, then reports completion with a one-cycle done pulse.
//  - Sits between the top-level user I/O (ui_in/uio_in) and the counter; its count drives uo_out.
// PARAMETERS
//  WIDTH   8   counter, argument and step width
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      controller can accept a command (=1 only in IDLE)
//  cmd_op      in   2      00 CLEAR, 01 LOAD, 10 RUN_N, 11 RUN_TO
//  cmd_arg     in   WIDTH  load value / step count / target value
//  abort       in   1      terminate RUN_N / RUN_TO early
//  count       out  WIDTH  current counter value
//  busy        out  1      1 in RUN_N / RUN_TO states
//  done        out  1      one-cycle pulse when a command completes
//  done_abort  out  1      valid with done: 1 = command ended by abort
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, count=0, remaining=0, target=0, done=0, done_abort=0.
//   - Mid-command reset discards the command.
//   - cmd_ready=1 from the first cycle after rst_n deasserts.
//  States: IDLE, RUN_N, RUN_TO, DONE. cmd_ready=(IDLE), busy=(RUN_N|RUN_TO), done=(DONE).
//  Accept = cmd_valid & cmd_ready, sampled at a rising edge. cmd_op/cmd_arg are sampled only at accept.
//  IDLE, accept:
//   - CLEAR: count<=0 at the accept edge; ->DONE.
//   - LOAD: count<=cmd_arg at the accept edge; ->DONE.
//   - RUN_N: remaining<=cmd_arg.
//       arg==0: ->DONE, count unchanged.
//       otherwise: ->RUN_N.
//   - RUN_TO: target<=cmd_arg.
//       count==arg: ->DONE, no increment.
//       otherwise: ->RUN_TO.
//  RUN_N, each edge: count<=count+1 and remaining<=remaining-1.
//   - When remaining==1 at the edge: ->DONE.
//   - Exactly N increments over N cycles in RUN_N.
//  RUN_TO, each edge: count<=count+1.
//   - When count+1==target: ->DONE.
//   - Wraps 255->0 as needed; up to 255 increments.
//  abort in RUN_N/RUN_TO:
//   - Takes priority over the increment at that edge: count holds, ->DONE with done_abort=1.
//   - abort has no effect in IDLE/DONE.
//  DONE: lasts exactly one cycle, then ->IDLE.
//   - done_abort=0 unless entered via abort.
//   - No command is accepted in DONE (cmd_ready=0); a held cmd_valid is accepted in the following IDLE cycle.
//  Arithmetic: modulo 2^WIDTH, no saturation, no overflow flag.
//  Latency, accept edge to done high:
//   - CLEAR, LOAD, RUN_N(0), RUN_TO(equal): 1 cycle.
//   - RUN_N(N): N+1 cycles.
//  Back-to-back commands: minimum spacing is 2 cycles (accept, DONE).
// STRUCTURE
//  Package counter_seq_pkg: op encodings (OP_CLEAR..OP_RUN_TO), state enum (ST_IDLE, ST_RUN_N, ST_RUN_TO, ST_DONE), WIDTH default.
//  Sub-module up_counter (WIDTH), owns the count register:
//   - Ports: clk, rst_n, clr, load_en, load, inc, out.
//   - Priority clr > load_en > inc.
//  The controller FSM drives clr/load_en/inc combinationally from state and accept; it owns remaining, target and done_abort.
// TESTING
//  1 Reset: rst_n=0 mid-RUN_N(200) -> count=0, busy=0, done=0 immediately; cmd_ready=1 one cycle after release.
//  2 LOAD 0xC5 then RUN_N 3 -> count 0xC5 at accept+1; 0xC8 after 3 RUN cycles; done pulse 4 cycles after RUN accept.
//  3 LOAD 0xFE, RUN_TO 0x01 -> count sequence FF,00,01; done with done_abort=0 and busy low the same cycle.
//  4 RUN_N 0 and RUN_TO equal to count -> done at accept+1, count unchanged, no increment.
//  5 LOAD 0x10, RUN_N 100, abort at 5th RUN cycle -> count=0x14 held, done=1 and done_abort=1 for one cycle.
//  6 cmd_valid held high continuously with alternating LOAD/CLEAR -> accepts every 2 cycles; cmd_ready=0 in DONE; no command lost or duplicated.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared encodings and types for the counter sequencer and its counter datapath.
package counter_seq_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'b00,
        OP_LOAD   = 2'b01,
        OP_RUN_N  = 2'b10,
        OP_RUN_TO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN_N  = 2'b01,
        ST_RUN_TO = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] arg;
    } cmd_t;

endpackage

// File: rtl/counter_sequencer_up_counter.sv
// Up-counter datapath owning the count register; priority clr > load_en > inc.
module up_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (clr) begin
            out <= '0;
        end else if (load_en) begin
            out <= load;
        end else if (inc) begin
            out <= out + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller sequencing an up-counter through CLEAR/LOAD/RUN_N/RUN_TO.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = counter_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             done_abort
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             done_abort_q, done_abort_d;
    logic             clr, load_en, inc;
    logic             accept;
    cmd_t             cmd;

    assign cmd       = '{op: op_e'(cmd_op), arg: cmd_arg};
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN_N) || (state_q == ST_RUN_TO);
    assign done      = (state_q == ST_DONE);
    assign done_abort = done_abort_q;
    assign accept    = cmd_valid && cmd_ready;

    up_counter #(.WIDTH(WIDTH)) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .load_en (load_en),
        .load    (cmd.arg),
        .inc     (inc),
        .out     (count)
    );

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            target_q     <= '0;
            done_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            target_q     <= target_d;
            done_abort_q <= done_abort_d;
        end
    end

    // Next-state and counter controls; abort beats the increment in the run states
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        target_d     = target_q;
        done_abort_d = 1'b0;
        clr          = 1'b0;
        load_en      = 1'b0;
        inc          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd.op)
                        OP_CLEAR: begin
                            clr     = 1'b1;
                            state_d = ST_DONE;
                        end
                        OP_LOAD: begin
                            load_en = 1'b1;
                            state_d = ST_DONE;
                        end
                        OP_RUN_N: begin
                            remaining_d = cmd.arg;
                            state_d     = (cmd.arg == '0) ? ST_DONE : ST_RUN_N;
                        end
                        OP_RUN_TO: begin
                            target_d = cmd.arg;
                            state_d  = (count == cmd.arg) ? ST_DONE : ST_RUN_TO;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN_N: begin
                if (abort) begin
                    done_abort_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    inc         = 1'b1;
                    remaining_d = remaining_q - WIDTH'(1);
                    if (remaining_q == WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN_TO: begin
                if (abort) begin
                    done_abort_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    inc = 1'b1;
                    if ((count + WIDTH'(1)) == target_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scenario bench for counter_sequencer with a completion scoreboard.
module tb_counter_sequencer;

    typedef struct packed {
        logic [7:0] count;
        logic       dab;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       abort;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       done_abort;

    int unsigned pass_cnt;
    int unsigned total_cnt;
    exp_t        exp_q[$];
    logic [7:0]  model_count;

    counter_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .done_abort (done_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one command starting at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [1:0] op, input logic [7:0] arg, output int ok);
        ok        = 0;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                ok = 1;
                return;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    // Cycles until done is seen, -1 on timeout
    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!done && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic check_completion(input string name);
        exp_t e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: done seen with empty scoreboard (count=%h)", name, count);
            return;
        end
        e = exp_q.pop_front();
        if (done !== 1'b1 || count !== e.count || done_abort !== e.dab)
            $display("FAIL %s: done=%b count=%h dab=%b, required done=1 count=%h dab=%b",
                     name, done, count, done_abort, e.count, e.dab);
        else
            pass_cnt++;
    endtask

    task automatic test_reset;
        int ok;
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (count !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || done_abort !== 1'b0)
            $display("FAIL reset_state: count=%h busy=%b done=%b dab=%b, required 00/0/0/0",
                     count, busy, done, done_abort);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset: cmd_ready=%b required 1", cmd_ready);
        else pass_cnt++;
        send(2'b10, 8'd200, ok);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || count !== 8'd5)
            $display("FAIL mid_run: busy=%b count=%h, required 1/05", busy, count);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (count !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL async_reset: count=%h busy=%b done=%b, required 00/0/0", count, busy, done);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || count !== 8'h00)
            $display("FAIL release: cmd_ready=%b busy=%b count=%h, required 1/0/00", cmd_ready, busy, count);
        else pass_cnt++;
        model_count = 8'h00;
    endtask

    task automatic test_load_run_n;
        int ok, cyc;
        send(2'b01, 8'hC5, ok);
        model_count = 8'hC5;
        exp_q.push_back('{count: model_count, dab: 1'b0});
        check_completion("load_c5");
        @(negedge clk);
        send(2'b10, 8'd3, ok);
        model_count = model_count + 8'd3;
        exp_q.push_back('{count: model_count, dab: 1'b0});
        wait_done(10, cyc);
        total_cnt++;
        if (cyc != 3) $display("FAIL run_n3_latency: done %0d cycles after accept+1, required 3", cyc);
        else pass_cnt++;
        check_completion("run_n3");
        @(negedge clk);
    endtask

    task automatic test_run_to_wrap;
        int ok;
        logic [7:0] seq [3];
        seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'h01;
        send(2'b01, 8'hFE, ok);
        model_count = 8'hFE;
        exp_q.push_back('{count: model_count, dab: 1'b0});
        check_completion("load_fe");
        @(negedge clk);
        send(2'b11, 8'h01, ok);
        model_count = 8'h01;
        exp_q.push_back('{count: model_count, dab: 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (count !== seq[i]) $display("FAIL run_to_seq%0d: count=%h required %h", i, count, seq[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL run_to_busy: busy=%b required 0 with done", busy);
        else pass_cnt++;
        check_completion("run_to_wrap");
        @(negedge clk);
    endtask

    task automatic test_zero_cases;
        int ok;
        send(2'b10, 8'd0, ok);
        exp_q.push_back('{count: model_count, dab: 1'b0});
        check_completion("run_n0");
        @(negedge clk);
        send(2'b11, model_count, ok);
        exp_q.push_back('{count: model_count, dab: 1'b0});
        check_completion("run_to_equal");
        @(negedge clk);
    endtask

    task automatic test_abort;
        int ok;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total_cnt++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || count !== model_count)
            $display("FAIL abort_idle: ready=%b done=%b count=%h, required 1/0/%h",
                     cmd_ready, done, count, model_count);
        else pass_cnt++;
        send(2'b01, 8'h10, ok);
        model_count = 8'h10;
        exp_q.push_back('{count: model_count, dab: 1'b0});
        check_completion("load_10");
        @(negedge clk);
        send(2'b10, 8'd100, ok);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        model_count = 8'h14;
        exp_q.push_back('{count: model_count, dab: 1'b1});
        check_completion("abort_run_n");
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || done_abort !== 1'b0 || count !== 8'h14 || busy !== 1'b0)
            $display("FAIL abort_after: done=%b dab=%b count=%h busy=%b, required 0/0/14/0",
                     done, done_abort, count, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        cmd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (cmd_ready !== 1'b1) $display("FAIL b2b_ready%0d: cmd_ready=%b required 1", k, cmd_ready);
            else pass_cnt++;
            if (k % 2 == 0) begin
                cmd_op  = 2'b01;
                cmd_arg = 8'(k * 37 + 9);
                model_count = cmd_arg;
            end else begin
                cmd_op  = 2'b00;
                cmd_arg = 8'hAA;
                model_count = 8'h00;
            end
            exp_q.push_back('{count: model_count, dab: 1'b0});
            @(negedge clk);
            total_cnt++;
            if (cmd_ready !== 1'b0) $display("FAIL b2b_done_ready%0d: cmd_ready=%b required 0", k, cmd_ready);
            else pass_cnt++;
            check_completion("b2b");
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        model_count = 8'h00;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_arg     = 8'h00;
        abort       = 1'b0;
        test_reset();
        test_load_run_n();
        test_run_to_wrap();
        test_zero_cases();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
